// File: rtl/fosfor_cipher_host_if.sv
// fosfor_cipher_host_if
// Nibble-serial host bridge between the 8-pin pad bus and a block-cipher
// engine with a Start/Ready handshake.
//
// Ports:
//   Clk_ik, Reset_irn       system clock, asynchronous active-low reset
//   Addr_ib, Data_ib        pin function select and pin write data
//   Data_ob                 registered pin read data (status or read result)
//   PlainText_ob, Key_ob    engine inputs, word-addressed registers
//   Start_o                 one-cycle engine start pulse
//   CipherText_ib, Ready_i  engine result and idle/result-valid flag
//
// Build option: define FOSFOR_AUTOINC_EN to post-increment the register
// address after every executed read or write command.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | no operation in flight
// S_PULSE  | Start_o asserted, engine launched
// S_SETTLE | engine Ready_i not yet trusted
// S_RUN    | waiting for Ready_i, finishes (Done) in first Ready_i cycle
module fosfor_cipher_host_if #(
  parameter int BUS_W    = 4,
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 8,
  parameter int BLOCK_W  = 64,
  parameter int KEY_W    = 80,
  parameter int KEY_BASE = 'h10
) (
  input  logic               Clk_ik,
  input  logic               Reset_irn,
  input  logic [1:0]         Addr_ib,
  input  logic [BUS_W-1:0]   Data_ib,
  output logic [DATA_W-1:0]  Data_ob,
  output logic [BLOCK_W-1:0] PlainText_ob,
  output logic [KEY_W-1:0]   Key_ob,
  output logic               Start_o,
  input  logic [BLOCK_W-1:0] CipherText_ib,
  input  logic               Ready_i
);

  localparam int NPT   = BLOCK_W / DATA_W;
  localparam int NKEY  = KEY_W / DATA_W;
  localparam int CNT_W = 2 * DATA_W;
  localparam logic [ADDR_W-1:0] A_TEST   = ADDR_W'(NPT);
  localparam logic [ADDR_W-1:0] A_CNT_LO = ADDR_W'(NPT + 1);
  localparam logic [ADDR_W-1:0] A_CNT_HI = ADDR_W'(NPT + 2);

  typedef enum logic [1:0] {S_IDLE, S_PULSE, S_SETTLE, S_RUN} state_t;
  state_t state, state_nxt;

  logic [3:0]        cmd;
  logic [DATA_W-1:0] input_data, output_data, test_reg, status, rd_data;
  logic [ADDR_W-1:0] reg_address;
  logic [CNT_W-1:0]  counter;
  logic              busy, done, error, finish;
  logic              clr, do_ld, do_rd, do_wr, do_start, start_ok;
  logic              rd_err, wr_err, err_set;
  logic              test_sel, cnt_lo_sel, cnt_hi_sel;
  logic [NPT-1:0]    pt_sel;
  logic [NKEY-1:0]   key_sel;

  // 1111 is reserved for clearing status; it never decodes as read/write/start.
  assign clr      = (cmd == 4'hF);
  assign do_ld    = cmd[0] && !clr;
  assign do_rd    = cmd[1] && !clr;
  assign do_wr    = cmd[2] && !clr;
  assign do_start = cmd[3] && !clr;

  assign busy     = (state != S_IDLE);
  assign Start_o  = (state == S_PULSE);
  assign finish   = (state == S_RUN) && Ready_i;
  assign start_ok = do_start && !busy && Ready_i;
  assign status   = DATA_W'({error, done, busy, Ready_i});

  assign test_sel   = (reg_address == A_TEST);
  assign cnt_lo_sel = (reg_address == A_CNT_LO);
  assign cnt_hi_sel = (reg_address == A_CNT_HI);

  always_comb begin
    pt_sel  = '0;
    key_sel = '0;
    for (int i = 0; i < NPT; i++)  pt_sel[i]  = (reg_address == ADDR_W'(i));
    for (int i = 0; i < NKEY; i++) key_sel[i] = (reg_address == ADDR_W'(KEY_BASE + i));
  end

  always_comb begin
    rd_data = '0;
    rd_err  = 1'b0;
    if (|pt_sel) begin
      // Ciphertext is not valid while the engine is working.
      if (busy) rd_err = 1'b1;
      else
        for (int i = 0; i < NPT; i++)
          if (pt_sel[i]) rd_data = CipherText_ib[i*DATA_W +: DATA_W];
    end else if (test_sel)   rd_data = test_reg;
    else if (cnt_lo_sel)     rd_data = counter[DATA_W-1:0];
    else if (cnt_hi_sel)     rd_data = counter[CNT_W-1:DATA_W];
    else                     rd_err  = 1'b1;
  end

  // Engine inputs are frozen while busy; everything except the test
  // register and the engine inputs is not writable.
  assign wr_err  = (|pt_sel || |key_sel) ? busy : !test_sel;
  assign err_set = (do_rd && rd_err) || (do_wr && wr_err) || (do_start && !start_ok);

  always_ff @(posedge Clk_ik or negedge Reset_irn) begin
    if (!Reset_irn) state <= S_IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start_ok) state_nxt = S_PULSE;
      S_PULSE:  state_nxt = S_SETTLE;
      S_SETTLE: state_nxt = S_RUN;
      S_RUN:    if (Ready_i) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk_ik or negedge Reset_irn) begin
    if (!Reset_irn) begin
      cmd          <= '0;
      input_data   <= '0;
      output_data  <= '0;
      Data_ob      <= '0;
      reg_address  <= '0;
      test_reg     <= '0;
      counter      <= '0;
      done         <= 1'b0;
      error        <= 1'b0;
      PlainText_ob <= '0;
      Key_ob       <= '0;
    end else begin
      cmd <= (Addr_ib == 2'b01) ? 4'(Data_ib) : 4'd0;
      if (Addr_ib == 2'b10) input_data <= {Data_ib, input_data[DATA_W-1:BUS_W]};
      Data_ob <= Addr_ib[1] ? output_data : status;

      // Read/write in this cycle already used the pre-load address.
      if (do_ld) reg_address <= input_data[ADDR_W-1:0];
`ifdef FOSFOR_AUTOINC_EN
      else if (do_rd || do_wr) reg_address <= reg_address + ADDR_W'(1);
`endif

      if (do_rd) output_data <= rd_data;
      if (do_wr && !wr_err) begin
        if (test_sel) test_reg <= input_data;
        for (int i = 0; i < NPT; i++)
          if (pt_sel[i]) PlainText_ob[i*DATA_W +: DATA_W] <= input_data;
        for (int i = 0; i < NKEY; i++)
          if (key_sel[i]) Key_ob[i*DATA_W +: DATA_W] <= input_data;
      end

      if (start_ok)                   counter <= '0;
      else if (busy && counter != '1) counter <= counter + CNT_W'(1);

      if (finish)               done <= 1'b1;
      else if (start_ok || clr) done <= 1'b0;

      if (err_set)  error <= 1'b1;
      else if (clr) error <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fosfor_cipher_host_if.sv
// Self-checking bench for fosfor_cipher_host_if. A behavioural engine stands
// in for the cipher: it answers the all-zero PRESENT-80 vector and, for other
// inputs, that vector XOR plaintext XOR key[63:0].
module tb_fosfor_cipher_host_if;
  localparam int KB = 'h10;
  localparam logic [63:0] PRESENT_ZERO = 64'h5579C1387B228445;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  addr;
  logic [3:0]  din;
  logic [7:0]  dout;
  logic [63:0] pt;
  logic [79:0] key;
  logic        start;
  logic [63:0] ct;
  logic        ready;

  fosfor_cipher_host_if dut (
    .Clk_ik(clk), .Reset_irn(rst_n), .Addr_ib(addr), .Data_ib(din),
    .Data_ob(dout), .PlainText_ob(pt), .Key_ob(key), .Start_o(start),
    .CipherText_ib(ct), .Ready_i(ready)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Engine model
  int          lat = 4;
  int          pulses;
  int          eng_cnt;
  logic        eng_ready;
  logic        force_low = 1'b0;
  logic [63:0] lpt;
  logic [79:0] lkey;
  assign ready = eng_ready & ~force_low;

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eng_ready <= 1'b1; eng_cnt <= 0; ct <= '0; pulses <= 0;
    end else if (start) begin
      eng_ready <= 1'b0; eng_cnt <= lat; pulses <= pulses + 1;
      lpt <= pt; lkey <= key;
    end else if (eng_cnt > 1) begin
      eng_cnt <= eng_cnt - 1;
    end else if (eng_cnt == 1) begin
      eng_cnt <= 0; eng_ready <= 1'b1;
      ct <= PRESENT_ZERO ^ lpt ^ lkey[63:0];
    end
  end

  // Reference model of the register file
  logic [7:0]  m_pt [8];
  logic [7:0]  m_key [10];
  logic [7:0]  m_test;
  logic [63:0] m_ct;
  logic [15:0] m_cnt;
  logic        m_err, m_done, m_busy;
  int          m_addr;

  function automatic logic [63:0] pt_vec();
    logic [63:0] v;
    for (int i = 0; i < 8; i++) v[i*8 +: 8] = m_pt[i];
    return v;
  endfunction

  function automatic logic [79:0] key_vec();
    logic [79:0] v;
    for (int i = 0; i < 10; i++) v[i*8 +: 8] = m_key[i];
    return v;
  endfunction

  function automatic bit in_key(input int a);
    return a >= KB && a < KB + 10;
  endfunction

  function automatic logic [7:0] exp_val(input int a);
    if (a < 8)       return m_busy ? 8'h00 : m_ct[a*8 +: 8];
    else if (a == 8) return m_test;
    else if (a == 9) return m_cnt[7:0];
    else if (a == 10) return m_cnt[15:8];
    return 8'h00;
  endfunction

  function automatic bit exp_rd_err(input int a);
    return (a < 8 && m_busy) || a > 10;
  endfunction

  function automatic bit exp_wr_err(input int a);
    if (a < 8 || in_key(a)) return m_busy;
    return a != 8;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_pt[i] = 8'h00;
    for (int i = 0; i < 10; i++) m_key[i] = 8'h00;
    m_test = 8'h00; m_ct = '0; m_cnt = '0;
    m_err = 1'b0; m_done = 1'b0; m_busy = 1'b0; m_addr = 0;
  endtask

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input logic [1:0] a, input logic [3:0] d);
    addr = a; din = d;
    @(posedge clk); #1;
  endtask

  task automatic shift_word(input logic [7:0] w);
    tick(2'b10, w[3:0]);
    tick(2'b10, w[7:4]);
  endtask

  task automatic command(input logic [3:0] c);
    tick(2'b01, c);
    tick(2'b00, 4'h0);
  endtask

  task automatic set_addr(input int a);
    shift_word(8'(a));
    command(4'h1);
    m_addr = a;
  endtask

  task automatic autoinc();
`ifdef FOSFOR_AUTOINC_EN
    m_addr = (m_addr + 1) & 255;
`endif
  endtask

  task automatic do_write(input logic [7:0] v);
    int a;
    a = m_addr;
    shift_word(v);
    command(4'h4);
    if (exp_wr_err(a)) m_err = 1'b1;
    else if (a < 8) m_pt[a] = v;
    else if (a == 8) m_test = v;
    else m_key[a-KB] = v;
    autoinc();
  endtask

  task automatic do_read(input string tag);
    int a;
    a = m_addr;
    tick(2'b01, 4'h2);
    tick(2'b11, 4'h0);
    tick(2'b11, 4'h0);
    check(tag, dout, exp_val(a));
    if (exp_rd_err(a)) m_err = 1'b1;
    autoinc();
  endtask

  task automatic check_status(input string tag);
    tick(2'b00, 4'h0);
    check(tag, dout, {4'h0, m_err, m_done, m_busy, !(m_busy || force_low)});
  endtask

  task automatic do_start(input string tag);
    logic go;
    go = !m_busy && !force_low;
    command(4'h8);
    check({tag, "_pulse"}, start, go);
    tick(2'b00, 4'h0);
    check({tag, "_single"}, start, 1'b0);
    if (go) begin m_busy = 1'b1; m_done = 1'b0; end
    else m_err = 1'b1;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    do begin
      tick(2'b00, 4'h0);
      n++;
    end while (!dout[2] && n < 300);
    check({tag, "_done"}, dout[2], 1'b1);
    m_busy = 1'b0; m_done = 1'b1; m_cnt = 16'(lat + 1);
    m_ct = PRESENT_ZERO ^ pt_vec() ^ key_vec()[63:0];
    check({tag, "_status"}, dout, {4'h0, m_err, 3'b101});
  endtask

  task automatic read_result(input string tag);
    for (int w = 0; w < 8; w++) begin
      set_addr(w);
      do_read({tag, "_ct"});
    end
    set_addr(9);  do_read({tag, "_cnt_lo"});
    set_addr(10); do_read({tag, "_cnt_hi"});
  endtask

  initial begin
    int p0;
    addr = 2'b00; din = 4'h0;
    model_reset();
    repeat (3) tick(2'b00, 4'h0);
    rst_n = 1'b1;
    tick(2'b00, 4'h0);

    // Reset in the middle of traffic
    set_addr(8);
    do_write(8'h3C);
    tick(2'b10, 4'h7);
    rst_n = 1'b0;
    #1;
    check("rst_dout", dout, 8'h00);
    check("rst_start", start, 1'b0);
    tick(2'b00, 4'h0);
    rst_n = 1'b1;
    model_reset();
    check_status("rst_status");
    set_addr(8);
    do_read("rst_test");

    // Test register round trip: nibble 5 then A
    set_addr(8);
    do_write(8'hA5);
    do_read("test_reg");
    check_status("test_noerr");

    // PRESENT-80 all-zero vector
    lat = int'($urandom_range(2, 12));
    do_start("present");
    wait_done("present");
    check("present_pulses", 80'(pulses), 80'd1);
    read_result("present");

    // Random key and plaintext
    for (int i = 0; i < 10; i++) begin
      set_addr(KB + i);
      do_write(8'($urandom));
    end
    for (int i = 0; i < 8; i++) begin
      set_addr(i);
      do_write(8'($urandom));
    end
    check("key_load", key, key_vec());
    check("pt_load", pt, pt_vec());

    // Guarded start, writes and reads while busy
    lat = int'($urandom_range(40, 60));
    p0 = pulses;
    do_start("op2");
    check_status("op2_busy");
    do_start("op2_again");
    check_status("op2_again_err");
    set_addr(KB + 3);
    do_write(~m_key[3]);
    check("key_frozen", key, key_vec());
    set_addr(2);
    do_read("ct_busy");
    wait_done("op2");
    check("op2_pulses", 80'(pulses), 80'(p0 + 1));
    read_result("op2");
    command(4'hF);
    m_err = 1'b0; m_done = 1'b0;
    check_status("clear");

    // Start refused while the engine is not ready
    force_low = 1'b1;
    do_start("not_ready");
    force_low = 1'b0;
    check_status("not_ready_err");
    command(4'hF);
    m_err = 1'b0;

    // Unmapped and read-only accesses
    set_addr(8'h30);
    do_read("unmapped");
    check_status("unmapped_err");
    command(4'hF);
    m_err = 1'b0;
    set_addr(9);
    do_write(8'($urandom));
    set_addr(9);
    do_read("cnt_ro");
    check_status("cnt_ro_err");
    command(4'hF);
    m_err = 1'b0;
    set_addr(KB);
    do_read("key_wo");
    check_status("key_wo_err");

    // Random test-register traffic
    for (int k = 0; k < 6; k++) begin
      set_addr(8);
      do_write(8'($urandom));
      set_addr(8);
      do_read("rand_test");
    end

`ifdef FOSFOR_AUTOINC_EN
    set_addr(KB);
    for (int i = 0; i < 10; i++) do_write(8'($urandom));
    check("autoinc_key", key, key_vec());
    set_addr(255);
    do_read("autoinc_ff");
    do_read("autoinc_wrap");
`else
    set_addr(8);
    do_write(8'($urandom));
    do_read("hold_addr1");
    do_read("hold_addr2");
`endif

    // Reset during an operation
    lat = 30;
    do_start("op3");
    repeat (3) tick(2'b00, 4'h0);
    rst_n = 1'b0;
    #1;
    check("rst_busy_start", start, 1'b0);
    check("rst_busy_dout", dout, 8'h00);
    tick(2'b00, 4'h0);
    rst_n = 1'b1;
    model_reset();
    check_status("rst_busy_status");
    check("rst_key", key, 80'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fosfor_cipher_host_if.md
Name: fosfor_cipher_host_if

Overview:
Parametrised nibble-serial host bridge between the 8-pin TinyTapeout pad bus and a block-cipher engine (core_serial style: Start/Ready, plaintext/key in, ciphertext out).
- Generalises the first-generation PRESENT top: configurable pin, word, block and key widths.
- Adds a shift-in assembly register, busy tracking with a guarded start, sticky done/error status and an encryption cycle counter.
- Sits directly under the project top; the engine is instantiated beside it.

Parameters:
BUS_W, 4, pin data width; DATA_W must be an integer multiple of BUS_W.
DATA_W, 8, internal register word width.
ADDR_W, 8, register address width.
BLOCK_W, 64, plaintext/ciphertext width; multiple of DATA_W.
KEY_W, 80, key width; multiple of DATA_W.
KEY_BASE, 'h10, first key word address.

Ports:
Clk_ik  in  1  system clock; all state on rising edge.
Reset_irn  in  1  asynchronous active-low reset.
Addr_ib  in  2  pin function select.
Data_ib  in  BUS_W  pin write data.
Data_ob  out  DATA_W  registered pin read data.
PlainText_ob  out  BLOCK_W  to engine.
Key_ob  out  KEY_W  to engine.
Start_o  out  1  one-cycle start pulse.
CipherText_ib  in  BLOCK_W  from engine.
Ready_i  in  1  engine idle/result valid.

Behaviour:
- Reset: every register clears to 0, including Data_ob, Start_o, address, status, counter, plaintext and key.
- Pin functions (Addr_ib):
  - 00: idle.
  - 01: capture Data_ib into the self-clearing command register.
  - 10: shift-in, InputData <= {Data_ib, InputData[DATA_W-1:BUS_W]}. The least-significant chunk is sent first; DATA_W/BUS_W writes complete a word.
  - 11: idle.
- Pin read: Data_ob is registered each cycle.
  - Addr_ib[1]=0: Data_ob <= Status.
  - Addr_ib[1]=1: Data_ob <= OutputData.
- Status word: bit0 Ready_i, bit1 Busy, bit2 Done (sticky), bit3 Error (sticky), rest 0.
- Command execution: the captured command executes in the cycle after capture, then clears. Command 4'b1111 clears Done and Error only. Otherwise bits are decoded independently:
  - bit0: RegAddress <= InputData[ADDR_W-1:0].
  - bit1: read at the current RegAddress.
  - bit2: write at the current RegAddress.
  - bit3: start.
  - Read and write in the same command as an address load use the pre-load address.
- Register map (word = DATA_W):
  - Addresses 0..BLOCK_W/DATA_W-1: write plaintext word n; read ciphertext word n (word 0 = LSBs).
  - BLOCK_W/DATA_W: test register, read/write.
  - +1 and +2: cycle counter low/high word, read-only.
  - KEY_BASE..KEY_BASE+KEY_W/DATA_W-1: key words, write-only.
  - Reads of write-only or unmapped addresses return 0 and set Error. Writes to read-only or unmapped addresses are dropped and set Error.
- Start handshake:
  - When start is decoded with Busy=0 and Ready_i=1: Start_o=1 for exactly one cycle; Busy<=1, Done<=0, counter<=0.
  - A start with Busy=1 or Ready_i=0 produces no pulse and sets Error.
- Busy phase:
  - Busy clears on the first cycle with Ready_i=1 at least 2 cycles after Start_o; Done<=1 in that cycle.
  - The counter (2*DATA_W bits) increments every Busy cycle and saturates at all-ones.
  - Plaintext and key writes while Busy are dropped and set Error; the engine inputs stay stable.
  - Ciphertext reads while Busy return 0 and set Error.
- Simultaneous events: Done clear (1111) and Done set in the same cycle resolve to set. Error set wins over clear.
- Reset mid-operation clears Busy/Done immediately; the engine is reset by the same net.
- Latency:
  - Pin write to register effect: 2 cycles (capture, execute).
  - Read command to OutputData valid: 2 cycles; to Data_ob: 3 cycles.

Optional Feature:
FOSFOR_AUTOINC_EN:
- Defined: after each executed read or write command, RegAddress increments by 1, wrapping at 2^ADDR_W-1 -> 0. Command bit0 in the same command still takes precedence for the next address.
- Undefined: RegAddress changes only by command bit0.

Test Plan:
- Reset: assert Reset_irn=0 mid-traffic -> Data_ob=0, Start_o=0, Status=0x01 with Ready_i=1; test register reads 0x00.
- Test register: shift nibbles 5 then A, load address 0x08, write, read -> Data_ob=0xA5 on Addr_ib=1x; no Error.
- PRESENT-80 vector: key all-0, plaintext all-0, start -> Start_o single pulse; Done=1 when Ready_i rises; ciphertext words 0..7 read 0x45,0x84,0x22,0x7B,0x38,0xC1,0x79,0x55; counter equals Busy cycle count.
- Guarded start: start again while Busy -> no second Start_o, Error=1; key write while Busy dropped (key output unchanged); command 1111 after completion -> Status Done=0, Error=0.
- Unmapped access: read address 0x30 -> 0x00 and Error=1; write to counter address -> value unchanged, Error=1.
- With FOSFOR_AUTOINC_EN: load address KEY_BASE, 10 consecutive writes -> Key_ob fully loaded in order; address 0xFF read then read -> second read from 0x00.
